// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types: default register-file geometry and the NZP condition-code layout.
package lc3_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam nzp_t NZP_RESET = 3'b010;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the LC-3 register file: one busy bit per register plus RAW/WAW stall detection.
// Optional macro REGFILE_BYPASS_EN masks hazard terms satisfied by a same-cycle writeback.
module regfile_scoreboard #(
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   WR_ADDR,
  input  logic                ISSUE,
  input  logic [ADDR_W-1:0]   ISSUE_DR,
  input  logic                USE_SR1,
  input  logic                USE_SR2,
  input  logic [ADDR_W-1:0]   SR1,
  input  logic [ADDR_W-1:0]   SR2,
  output logic                HAZARD,
  output logic [NUM_REGS-1:0] BUSY
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wb_sr1, wb_sr2, wb_dr;
  logic                raw1, raw2, waw;
  logic                hazard;

`ifdef REGFILE_BYPASS_EN
  // A writeback landing this cycle already resolves the dependency it targets.
  assign wb_sr1 = WE && (WR_ADDR == SR1);
  assign wb_sr2 = WE && (WR_ADDR == SR2);
  assign wb_dr  = WE && (WR_ADDR == ISSUE_DR);
`else
  assign wb_sr1 = 1'b0;
  assign wb_sr2 = 1'b0;
  assign wb_dr  = 1'b0;
`endif

  assign raw1   = USE_SR1 && busy_q[SR1] && !wb_sr1;
  assign raw2   = USE_SR2 && busy_q[SR2] && !wb_sr2;
  assign waw    = busy_q[ISSUE_DR] && !wb_dr;
  assign hazard = ISSUE && (raw1 || raw2 || waw);

  // Set has priority so an issue retargeting a register being written back stays tracked.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ISSUE && !hazard && (ISSUE_DR == ADDR_W'(i)))
        busy_d[i] = 1'b1;
      else if (WE && (WR_ADDR == ADDR_W'(i)))
        busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign HAZARD = hazard;
  assign BUSY   = busy_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// LC-3 general-purpose register file with two async read ports, NZP register and busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module reg_file_scoreboard
  import lc3_pkg::*;
#(
  parameter int                 DATA_W    = DATA_W_DEF,
  parameter int                 NUM_REGS  = NUM_REGS_DEF,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        WE,
  input  logic [$clog2(NUM_REGS)-1:0] WR_ADDR,
  input  logic [DATA_W-1:0]           WR_DATA,
  input  logic                        LD_CC,
  input  logic [$clog2(NUM_REGS)-1:0] SR1,
  input  logic [$clog2(NUM_REGS)-1:0] SR2,
  output logic [DATA_W-1:0]           SR1_Out,
  output logic [DATA_W-1:0]           SR2_Out,
  input  logic                        ISSUE,
  input  logic [$clog2(NUM_REGS)-1:0] ISSUE_DR,
  input  logic                        USE_SR1,
  input  logic                        USE_SR2,
  output logic                        HAZARD,
  output logic [NUM_REGS-1:0]         BUSY,
  output logic [2:0]                  NZP
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  nzp_t              nzp_q, nzp_d;

  // Condition codes from the two's-complement sign and a zero test; exactly one bit is set.
  function automatic nzp_t cc_from(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] sv;
    nzp_t                     cc;
    sv   = v;
    cc.n = (sv < 0);
    cc.z = (v == '0);
    cc.p = !cc.n && !cc.z;
    return cc;
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sr,
                                                  input logic [DATA_W-1:0] stored);
`ifdef REGFILE_BYPASS_EN
    return (WE && (WR_ADDR == sr)) ? WR_DATA : stored;
`else
    return (sr == sr) ? stored : stored;
`endif
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (WE)
      regs_d[WR_ADDR] = WR_DATA;
  end

  assign nzp_d = LD_CC ? cc_from(WR_DATA) : nzp_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= RESET_VAL;
      nzp_q <= NZP_RESET;
    end else begin
      regs_q <= regs_d;
      nzp_q  <= nzp_d;
    end
  end

  assign SR1_Out = read_port(SR1, regs_q[SR1]);
  assign SR2_Out = read_port(SR2, regs_q[SR2]);
  assign NZP     = nzp_q;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .Clk      (Clk),
    .Reset    (Reset),
    .WE       (WE),
    .WR_ADDR  (WR_ADDR),
    .ISSUE    (ISSUE),
    .ISSUE_DR (ISSUE_DR),
    .USE_SR1  (USE_SR1),
    .USE_SR2  (USE_SR2),
    .SR1      (SR1),
    .SR2      (SR2),
    .HAZARD   (HAZARD),
    .BUSY     (BUSY)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: stimulus queues expected outputs, a negedge monitor checks them.
module tb_reg_file_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int SIG_SR1 = 0, SIG_SR2 = 1, SIG_HAZ = 2, SIG_BUSY = 3, SIG_NZP = 4;

  logic        clk = 1'b0;
  logic        Reset, WE, LD_CC, ISSUE, USE_SR1, USE_SR2;
  logic [2:0]  WR_ADDR, SR1, SR2, ISSUE_DR;
  logic [15:0] WR_DATA, SR1_Out, SR2_Out;
  logic        HAZARD;
  logic [7:0]  BUSY;
  logic [2:0]  NZP;

  typedef struct {
    int          sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] mon_act;
  int          total  = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard #(.DATA_W(16), .NUM_REGS(8), .RESET_VAL(16'h0000)) dut (
    .Clk(clk), .Reset(Reset), .WE(WE), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .LD_CC(LD_CC),
    .SR1(SR1), .SR2(SR2), .SR1_Out(SR1_Out), .SR2_Out(SR2_Out),
    .ISSUE(ISSUE), .ISSUE_DR(ISSUE_DR), .USE_SR1(USE_SR1), .USE_SR2(USE_SR2),
    .HAZARD(HAZARD), .BUSY(BUSY), .NZP(NZP)
  );

  task automatic expect_val(input int sig, input logic [15:0] exp, input string name);
    exp_t e;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    WE = 1'b0; LD_CC = 1'b0; ISSUE = 1'b0; USE_SR1 = 1'b0; USE_SR2 = 1'b0;
  endtask

  // Monitor: everything queued during a cycle is checked at that cycle's falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e.sig)
        SIG_SR1:  mon_act = SR1_Out;
        SIG_SR2:  mon_act = SR2_Out;
        SIG_HAZ:  mon_act = {15'b0, HAZARD};
        SIG_BUSY: mon_act = {8'b0, BUSY};
        default:  mon_act = {13'b0, NZP};
      endcase
      total++;
      if (mon_act === mon_e.exp)
        passed++;
      else
        $display("FAIL %s: actual=%h required=%h", mon_e.name, mon_act, mon_e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; WE = 1'b0; LD_CC = 1'b0; ISSUE = 1'b0; USE_SR1 = 1'b0; USE_SR2 = 1'b0;
    WR_ADDR = '0; SR1 = '0; SR2 = '0; ISSUE_DR = '0; WR_DATA = '0;
    step(); step();
    Reset = 1'b0;

    // Preload every register, then read back on both ports
    for (int i = 0; i < 8; i++) begin
      WE = 1'b1; WR_ADDR = 3'(i); WR_DATA = 16'h1000 + 16'(i);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(7 - i);
      expect_val(SIG_SR1, 16'h1000 + 16'(i), "preload_sr1");
      expect_val(SIG_SR2, 16'h1000 + 16'(7 - i), "preload_sr2");
      step();
    end

    // Reset dominates a simultaneous write, issue and CC load
    Reset = 1'b1; WE = 1'b1; WR_ADDR = 3'd1; WR_DATA = 16'hAAAA; LD_CC = 1'b1;
    ISSUE = 1'b1; ISSUE_DR = 3'd3;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      expect_val(SIG_SR1, 16'h0000, "reset_reg");
      if (i == 0) begin
        expect_val(SIG_BUSY, 16'h0000, "reset_busy");
        expect_val(SIG_NZP, 16'h0002, "reset_nzp");
      end
      step();
    end

    // Write R3 with negative data and CC load
    WE = 1'b1; WR_ADDR = 3'd3; WR_DATA = 16'hBEEF; LD_CC = 1'b1; SR1 = 3'd3;
    expect_val(SIG_SR1, BYP ? 16'hBEEF : 16'h0000, "write_same_cycle");
    step();
    SR1 = 3'd3; LD_CC = 1'b1; WR_DATA = 16'h0001;
    expect_val(SIG_SR1, 16'hBEEF, "write_r3");
    expect_val(SIG_NZP, 16'h0004, "nzp_neg");
    step();
    SR1 = 3'd3; LD_CC = 1'b1; WR_DATA = 16'h0000;
    expect_val(SIG_SR1, 16'hBEEF, "we0_no_write");
    expect_val(SIG_NZP, 16'h0001, "nzp_pos");
    step();
    expect_val(SIG_NZP, 16'h0002, "nzp_zero");

    // RAW stall on R5
    ISSUE = 1'b1; ISSUE_DR = 3'd5;
    expect_val(SIG_HAZ, 16'h0000, "issue_r5_nohaz");
    step();
    ISSUE = 1'b1; USE_SR1 = 1'b1; SR1 = 3'd5; ISSUE_DR = 3'd6;
    expect_val(SIG_BUSY, 16'h0020, "busy5_set");
    expect_val(SIG_HAZ, 16'h0001, "raw_sr1");
    step();
    ISSUE = 1'b1; USE_SR1 = 1'b1;
    expect_val(SIG_BUSY, 16'h0020, "stall_busy_unchanged");
    expect_val(SIG_HAZ, 16'h0001, "raw_sr1_held");
    step();
    ISSUE = 1'b1; USE_SR1 = 1'b1; WE = 1'b1; WR_ADDR = 3'd5; WR_DATA = 16'h1234;
    expect_val(SIG_HAZ, BYP ? 16'h0000 : 16'h0001, "raw_wb_same_cycle");
    step();
    ISSUE = !BYP; USE_SR1 = 1'b1;
    expect_val(SIG_BUSY, BYP ? 16'h0040 : 16'h0000, "busy5_cleared");
    expect_val(SIG_HAZ, 16'h0000, "haz_dropped");
    step();
    SR1 = 3'd5; WE = 1'b1; WR_ADDR = 3'd6; WR_DATA = 16'h0006;
    expect_val(SIG_SR1, 16'h1234, "r5_wb_data");
    expect_val(SIG_BUSY, 16'h0040, "busy6_set");
    step();

    // RAW on SR2 and USE_SR2 gating
    ISSUE = 1'b1; ISSUE_DR = 3'd1;
    expect_val(SIG_BUSY, 16'h0000, "busy6_cleared");
    step();
    ISSUE = 1'b1; USE_SR2 = 1'b1; SR2 = 3'd1; ISSUE_DR = 3'd2;
    expect_val(SIG_HAZ, 16'h0001, "raw_sr2");
    step();
    ISSUE = 1'b1; SR2 = 3'd1; ISSUE_DR = 3'd2;
    expect_val(SIG_HAZ, 16'h0000, "use_sr2_low");
    step();

    // Simultaneous set and clear of R4: set wins
    ISSUE = 1'b1; ISSUE_DR = 3'd4; WE = 1'b1; WR_ADDR = 3'd4; WR_DATA = 16'h5555;
    expect_val(SIG_BUSY, 16'h0006, "busy_1_2");
    expect_val(SIG_HAZ, 16'h0000, "issue_r4_nohaz");
    step();
    SR1 = 3'd4;
    expect_val(SIG_SR1, 16'h5555, "r4_written");
    expect_val(SIG_BUSY, 16'h0016, "set_wins");
    step();

    // WAW stall on R7, then reset mid-stall
    ISSUE = 1'b1; ISSUE_DR = 3'd7;
    step();
    ISSUE = 1'b1; ISSUE_DR = 3'd7;
    expect_val(SIG_BUSY, 16'h0096, "busy7_set");
    expect_val(SIG_HAZ, 16'h0001, "waw_r7");
    step();
    Reset = 1'b1; ISSUE = 1'b1; ISSUE_DR = 3'd7;
    expect_val(SIG_HAZ, 16'h0001, "waw_during_reset");
    step();
    Reset = 1'b0; ISSUE = 1'b1; ISSUE_DR = 3'd7;
    expect_val(SIG_BUSY, 16'h0000, "reset_mid_busy");
    expect_val(SIG_HAZ, 16'h0000, "reset_mid_haz");
    step();

    // Write to a non-busy register, then WAW with same-cycle writeback
    WE = 1'b1; WR_ADDR = 3'd2; WR_DATA = 16'h8000; LD_CC = 1'b1;
    step();
    SR1 = 3'd2; ISSUE = 1'b1; ISSUE_DR = 3'd7; WE = 1'b1; WR_ADDR = 3'd7; WR_DATA = 16'h0042;
    expect_val(SIG_SR1, 16'h8000, "nonbusy_write");
    expect_val(SIG_BUSY, 16'h0080, "nonbusy_stays_clear");
    expect_val(SIG_NZP, 16'h0004, "nzp_min_neg");
    expect_val(SIG_HAZ, BYP ? 16'h0000 : 16'h0001, "waw_wb_same_cycle");
    step();
    SR1 = 3'd7;
    expect_val(SIG_BUSY, BYP ? 16'h0080 : 16'h0000, "waw_wb_busy");
    expect_val(SIG_SR1, 16'h0042, "r7_written");
    step();

    // Forwarding of a zero write to SR2
    WE = 1'b1; WR_ADDR = 3'd4; WR_DATA = 16'h7777;
    step();
    WE = 1'b1; WR_ADDR = 3'd4; WR_DATA = 16'h0000; LD_CC = 1'b1; SR2 = 3'd4;
    expect_val(SIG_SR2, BYP ? 16'h0000 : 16'h7777, "sr2_forward");
    step();
    SR2 = 3'd4;
    expect_val(SIG_SR2, 16'h0000, "r4_zero");
    expect_val(SIG_NZP, 16'h0002, "nzp_zero_wb");
    step();

    total++;
    if (SR2_Out === 16'h0000)
      passed++;
    else
      $display("FAIL final_sr2: actual=%h required=0000", SR2_Out);
    total++;
    if (NZP === 3'b010)
      passed++;
    else
      $display("FAIL final_nzp: actual=%b required=010", NZP);
    total++;
    if (HAZARD === 1'b0)
      passed++;
    else
      $display("FAIL final_haz: actual=%b required=0", HAZARD);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++)
      @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      $display("FAIL %s: actual=unchecked required=%h", mon_e.name, mon_e.exp);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
